vga_write_arbiter: RTL

- Shares the single VGA framebuffer write port (waddr/wdata/wr_en into vgadisplay) between two independent requesters, e.g. the core and a console/terminal writer.
- Uses a valid/ready handshake per requester with round-robin arbitration, and drives one registered write per cycle to the display.
- Optionally contains a clear-screen engine that sweeps the whole buffer with a fill byte.
- Sits in fpga_root between the requesters and vgadisplay, in the clk48 domain.

---
 rtl/vga_write_arbiter_if.sv | 37 +++
 rtl/vga_write_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter_if.sv
// Requester, clear-control and framebuffer write signals shared by vga_write_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requester and the display.
interface vga_write_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_valid;
  logic              req1_ready;
  logic              clear_start;
  logic [DATA_W-1:0] clear_fill;
  logic              clear_busy;
  logic [ADDR_W-1:0] vga_waddr;
  logic [DATA_W-1:0] vga_wdata;
  logic              vga_wr_en;

  modport master (
    output req0_addr, req0_data, req0_valid,
    output req1_addr, req1_data, req1_valid,
    output clear_start, clear_fill,
    input  req0_ready, req1_ready, clear_busy,
    input  vga_waddr, vga_wdata, vga_wr_en
  );

  modport slave (
    input  req0_addr, req0_data, req0_valid,
    input  req1_addr, req1_data, req1_valid,
    input  clear_start, clear_fill,
    output req0_ready, req1_ready, clear_busy,
    output vga_waddr, vga_wdata, vga_wr_en
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter for two requesters that share the framebuffer write port. It issues one registered write per cycle.
// Define VGA_WRITE_ARBITER_CLEAR_EN to add the clear-screen sweep engine.
module vga_write_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int CLEAR_WORDS = 16384
) (
  input logic                clk48,
  input logic                rst,
  vga_write_arbiter_if.slave bus
);

  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              last_grant_q, last_grant_d;
  logic              arb_en;
  logic              grant0;
  logic              grant1;

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  // state | meaning
  // IDLE  | arbitrate between req0 and req1
  // CLEAR | write the fill byte to 0..CLEAR_WORDS-1 while both requesters are stalled
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // The counter is one bit wider than the address, so a sweep over the full 2^ADDR_W range ends without wrapping.
  localparam logic [ADDR_W:0] CLEAR_END = (ADDR_W+1)'(CLEAR_WORDS);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              busy_q, busy_d;
`else
  logic unused_clear;
  assign unused_clear = ^{bus.clear_start, bus.clear_fill};
`endif

  always_comb begin
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wr_en_d      = 1'b0;
    last_grant_d = last_grant_q;
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    busy_d  = busy_q;
    arb_en  = !rst && (state_q == ST_IDLE) && !bus.clear_start;
`else
    arb_en  = !rst;
`endif
    // A requester wins when it is the only one valid, or when the other one won the previous contest.
    grant0 = arb_en && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1 = arb_en && bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    if (grant0) begin
      waddr_d      = bus.req0_addr;
      wdata_d      = bus.req0_data;
      wr_en_d      = 1'b1;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      waddr_d      = bus.req1_addr;
      wdata_d      = bus.req1_data;
      wr_en_d      = 1'b1;
      last_grant_d = 1'b1;
    end

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
    if (state_q == ST_IDLE) begin
      // Address 0 is written on the entry edge, so the first busy cycle already carries its strobe.
      if (bus.clear_start) begin
        state_d = ST_CLEAR;
        busy_d  = 1'b1;
        fill_d  = bus.clear_fill;
        waddr_d = '0;
        wdata_d = bus.clear_fill;
        wr_en_d = 1'b1;
        cnt_d   = CNT_ONE;
      end
    end else if (cnt_q == CLEAR_END) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      waddr_d = cnt_q[ADDR_W-1:0];
      wdata_d = fill_q;
      wr_en_d = 1'b1;
      cnt_d   = cnt_q + CNT_ONE;
    end
`endif
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      waddr_q      <= '0;
      wdata_q      <= '0;
      wr_en_q      <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fill_q       <= '0;
      busy_q       <= 1'b0;
`endif
    end else begin
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wr_en_q      <= wr_en_d;
      last_grant_q <= last_grant_d;
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      busy_q       <= busy_d;
`endif
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.vga_waddr  = waddr_q;
  assign bus.vga_wdata  = wdata_q;
  assign bus.vga_wr_en  = wr_en_q;
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  assign bus.clear_busy = busy_q;
`else
  assign bus.clear_busy = 1'b0;
`endif

endmodule
